// File: rtl/tx_frame_scheduler_if.sv
// Stream bundle between the two symbol sources, the frame scheduler and the modulator.
// The master modport is the scheduler side; slave is the surrounding environment.
interface tx_frame_scheduler_if;
    logic       enable;
    logic       src0_valid;
    logic [1:0] src0_data;
    logic       src0_ready;
    logic       src1_valid;
    logic [1:0] src1_data;
    logic       src1_ready;
    logic       out_valid;
    logic [1:0] out_data;
    logic       out_ready;
    logic [1:0] grant;
    logic       busy;
    logic       frame_done;

    modport master (
        input  enable, src0_valid, src0_data, src1_valid, src1_data, out_ready,
        output src0_ready, src1_ready, out_valid, out_data, grant, busy, frame_done
    );

    modport slave (
        output enable, src0_valid, src0_data, src1_valid, src1_data, out_ready,
        input  src0_ready, src1_ready, out_valid, out_data, grant, busy, frame_done
    );
endinterface

// File: rtl/tx_frame_scheduler.sv
// Frames the modulator symbol stream as preamble + payload from one of two
// round-robin sources + fill gap; the grant is held for the whole frame.
module tx_frame_scheduler #(
    parameter int          PRE_LEN     = 16,
    parameter logic [31:0] PRE_PATTERN = 32'hF0F0_CCCC,
    parameter int          FRAME_LEN   = 64,
    parameter int          GAP_LEN     = 8,
    parameter logic [1:0]  FILL_SYM    = 2'b00
) (
    input  logic                   clk,
    input  logic                   rst,
    tx_frame_scheduler_if.master   bus
);
    localparam int MAX_A = (PRE_LEN > FRAME_LEN) ? PRE_LEN : FRAME_LEN;
    localparam int MAX_B = (MAX_A > GAP_LEN) ? MAX_A : GAP_LEN;
    localparam int MAX_C = (MAX_B > 2) ? MAX_B : 2;
    localparam int CW    = $clog2(MAX_C);

    localparam logic [CW-1:0] PRE_LAST   = CW'(PRE_LEN - 1);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] GAP_LAST   = (GAP_LEN > 0) ? CW'(GAP_LEN - 1) : '0;

    typedef enum logic [1:0] {IDLE, PRE, PAY, GAP} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [1:0]    grant_q, grant_d;
    logic          last_q, last_d;   // index of the source that owned the previous frame

    logic          ov, r0, r1, fd, xfer, sel;
    logic [1:0]    od;
    logic [3:0]    pre_idx;

    assign sel     = grant_q[1];
    assign pre_idx = 4'(cnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        grant_d = grant_q;
        last_d  = last_q;
        ov      = 1'b0;
        od      = 2'b00;
        r0      = 1'b0;
        r1      = 1'b0;
        fd      = 1'b0;
        xfer    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.enable && (bus.src0_valid || bus.src1_valid)) begin
                    // On a tie the source that did not own the last frame wins.
                    if (bus.src0_valid && bus.src1_valid)
                        grant_d = last_q ? 2'b01 : 2'b10;
                    else
                        grant_d = bus.src0_valid ? 2'b01 : 2'b10;
                    cnt_d   = '0;
                    state_d = PRE;
                end
            end
            PRE: begin
                ov   = 1'b1;
                od   = PRE_PATTERN[{pre_idx, 1'b0} +: 2];
                xfer = bus.out_ready;
                if (xfer) begin
                    if (cnt == PRE_LAST) begin
                        cnt_d   = '0;
                        state_d = PAY;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end
            PAY: begin
                ov   = sel ? bus.src1_valid : bus.src0_valid;
                od   = sel ? bus.src1_data  : bus.src0_data;
                r0   = ~sel & bus.out_ready;
                r1   = sel & bus.out_ready;
                xfer = ov & bus.out_ready;
                if (xfer) begin
                    if (cnt == FRAME_LAST) begin
                        cnt_d  = '0;
                        last_d = sel;
                        if (GAP_LEN == 0) begin
                            fd      = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end
            GAP: begin
                ov   = 1'b1;
                od   = FILL_SYM;
                xfer = bus.out_ready;
                if (xfer) begin
                    if (cnt == GAP_LAST) begin
                        cnt_d   = '0;
                        fd      = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.out_valid  = ov;
    assign bus.out_data   = od;
    assign bus.src0_ready = r0;
    assign bus.src1_ready = r1;
    assign bus.frame_done = fd;
    assign bus.busy       = (state != IDLE);
    assign bus.grant      = (state == IDLE) ? 2'b00 : grant_q;
endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Randomized bench for tx_frame_scheduler: a transfer-indexed frame model
// predicts every output each cycle from the frame layout and round-robin rule.
module tb_tx_frame_scheduler;
    localparam int          PRE_LEN     = 16;
    localparam int          FRAME_LEN   = 64;
    localparam int          GAP_LEN     = 8;
    localparam int          TOTAL       = PRE_LEN + FRAME_LEN + GAP_LEN;
    localparam logic [31:0] PRE_PATTERN = 32'hF0F0_CCCC;
    localparam logic [1:0]  FILL_SYM    = 2'b00;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tx_frame_scheduler_if bus();

    tx_frame_scheduler #(
        .PRE_LEN(PRE_LEN), .PRE_PATTERN(PRE_PATTERN), .FRAME_LEN(FRAME_LEN),
        .GAP_LEN(GAP_LEN), .FILL_SYM(FILL_SYM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // reference model state: frame position counted in transfers
    bit         in_frame = 0;
    int         pos      = 0;
    int         g        = 0;
    int         last_g   = 1;
    int         frames   = 0;
    int         pops     = 0;
    int         grant_log[$];
    bit         prev_hold = 0;
    logic [1:0] prev_data = 2'b00;

    // source emulation
    logic [1:0] tbl[2][1024];
    int         seq[2];
    bit         pop_pend[2];
    bit         held[2];
    int         stall_left[2];
    int         pct[2];
    int         rdy_pct = 100;

    function automatic logic [1:0] pre_sym(input int k);
        logic [31:0] pat;
        pat = PRE_PATTERN;
        return pat[2*k +: 2];
    endfunction

    task automatic sample();
        logic       v[2];
        logic [1:0] d[2];
        logic       ev, xfer;
        logic [1:0] ed, er;
        v[0] = bus.src0_valid; v[1] = bus.src1_valid;
        d[0] = bus.src0_data;  d[1] = bus.src1_data;
        if (!rst) begin
            chk("rst_busy", bus.busy, 0);
            chk("rst_valid", bus.out_valid, 0);
            chk("rst_grant", bus.grant, 0);
            chk("rst_ready", {bus.src1_ready, bus.src0_ready}, 0);
            chk("rst_done", bus.frame_done, 0);
            in_frame = 0; last_g = 1; prev_hold = 0;
            return;
        end
        if (!in_frame) begin
            chk("idle_busy", bus.busy, 0);
            chk("idle_valid", bus.out_valid, 0);
            chk("idle_grant", bus.grant, 0);
            chk("idle_ready", {bus.src1_ready, bus.src0_ready}, 0);
            chk("idle_done", bus.frame_done, 0);
            if (bus.enable && (v[0] || v[1])) begin
                if (v[0] && v[1]) g = 1 - last_g;
                else              g = v[1] ? 1 : 0;
                in_frame = 1; pos = 0; pops = 0; prev_hold = 0;
            end
            return;
        end
        chk("grant", bus.grant, (g == 1) ? 2'b10 : 2'b01);
        chk("busy", bus.busy, 1);
        if (pos < PRE_LEN) begin
            ev = 1'b1; ed = pre_sym(pos); er = 2'b00;
        end else if (pos < PRE_LEN + FRAME_LEN) begin
            ev = v[g]; ed = d[g]; er = bus.out_ready ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00;
        end else begin
            ev = 1'b1; ed = FILL_SYM; er = 2'b00;
        end
        chk("out_valid", bus.out_valid, ev);
        if (ev) chk("out_data", bus.out_data, ed);
        if (prev_hold && bus.out_valid) chk("hold_data", bus.out_data, prev_data);
        chk("src_ready", {bus.src1_ready, bus.src0_ready}, er);
        xfer = ev && bus.out_ready;
        chk("frame_done", bus.frame_done, xfer && (pos == TOTAL - 1));
        prev_hold = bus.out_valid && !bus.out_ready;
        prev_data = bus.out_data;
        if (xfer) begin
            if (pos >= PRE_LEN && pos < PRE_LEN + FRAME_LEN) begin
                pop_pend[g] = 1; pops++;
            end
            pos++;
            if (pos == TOTAL) begin
                chk("pay_count", pops, FRAME_LEN);
                in_frame = 0; last_g = g; frames++;
                grant_log.push_back(g);
            end
        end
    endtask

    task automatic drive();
        logic vv[2];
        for (int s = 0; s < 2; s++) begin
            if (pop_pend[s]) begin
                seq[s]++; pop_pend[s] = 0; held[s] = 0;
            end
            if (!held[s]) held[s] = ($urandom_range(99) < pct[s]);
            if (stall_left[s] > 0) begin
                vv[s] = 1'b0; stall_left[s]--;
            end else begin
                vv[s] = held[s];
            end
        end
        bus.src0_valid = vv[0];
        bus.src1_valid = vv[1];
        bus.src0_data  = tbl[0][seq[0] % 1024];
        bus.src1_data  = tbl[1][seq[1] % 1024];
        bus.out_ready  = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
    endtask

    task automatic cycle();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_frames(input int n, input int budget, input string tag);
        int target, k;
        target = frames + n;
        k = 0;
        while (frames < target && k < budget) begin
            cycle(); k++;
        end
        chk(tag, frames >= target, 1);
    endtask

    task automatic quiesce();
        int k;
        bus.enable = 1'b0;
        rdy_pct = 100;
        k = 0;
        while (in_frame && k < 400) begin
            cycle(); k++;
        end
        chk("quiesce_to", in_frame, 0);
    endtask

    task automatic wait_pos(input int p, input string tag);
        int k;
        k = 0;
        while (!(in_frame && pos == p) && k < 600) begin
            cycle(); k++;
        end
        chk(tag, in_frame && pos == p, 1);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 1024; i++) tbl[s][i] = 2'($urandom);
            seq[s] = 0; pop_pend[s] = 0; held[s] = 0; stall_left[s] = 0;
        end
        // reset with src0 valid and enable high
        pct[0] = 100; pct[1] = 0; rdy_pct = 100;
        bus.enable = 1'b1;
        drive();
        repeat (3) cycle();
        rst = 1'b1;
        run_frames(1, 200, "first_frame_to");
        chk("first_grant", grant_log[0], 0);

        // both sources always valid: grants alternate, one IDLE cycle apart
        quiesce();
        pct[0] = 100; pct[1] = 100;
        bus.enable = 1'b1;
        begin
            int base;
            base = grant_log.size();
            run_frames(3, 400, "alt_frames_to");
            for (int i = base + 1; i < grant_log.size(); i++)
                chk("alternate", grant_log[i] ^ grant_log[i-1], 1);
        end

        // src1 stalls for 5 cycles mid-payload
        quiesce();
        pct[0] = 0; held[0] = 0; pct[1] = 100;
        bus.enable = 1'b1;
        wait_pos(PRE_LEN + 20, "stall_pos_to");
        chk("stall_grant", g, 1);
        stall_left[1] = 5;
        run_frames(1, 200, "stall_frame_to");

        // random backpressure and source gaps
        pct[0] = 60; pct[1] = 60; rdy_pct = 50;
        bus.enable = 1'b1;
        repeat (1500) cycle();

        // drop enable mid-payload: frame completes, then stays idle
        quiesce();
        pct[0] = 100; pct[1] = 100;
        bus.enable = 1'b1;
        wait_pos(PRE_LEN + 10, "dis_pos_to");
        bus.enable = 1'b0;
        run_frames(1, 200, "dis_frame_to");
        repeat (20) cycle();
        chk("dis_idle_busy", bus.busy, 0);

        // asynchronous reset mid-preamble
        bus.enable = 1'b1;
        wait_pos(5, "arst_pos_to");
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_data", bus.out_data, 0);
        chk("arst_grant", bus.grant, 0);
        chk("arst_ready", {bus.src1_ready, bus.src0_ready}, 0);
        in_frame = 0; last_g = 1; prev_hold = 0;
        repeat (3) cycle();
        rst = 1'b1;
        begin
            int base;
            base = grant_log.size();
            run_frames(1, 200, "arst_frame_to");
            if (grant_log.size() > base) chk("arst_tie_grant", grant_log[base], 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tx_frame_scheduler.md
Name: tx_frame_scheduler

Overview:
- Sequences the transmit symbol stream feeding the I/Q modulator and shares it between two 2-bit symbol sources (src0: test pattern source, src1: payload source).
- Builds each frame as a fixed preamble, then FRAME_LEN payload symbols from one granted source, then a fill gap.
- Arbitrates round-robin per frame and holds the grant for the whole frame.

Parameters:
- PRE_LEN, 16, number of preamble symbols (1..16).
- PRE_PATTERN, 32'hF0F0_CCCC, preamble symbol k = PRE_PATTERN[2k+1:2k]; k=0 is sent first.
- FRAME_LEN, 64, payload symbols per frame (>=1).
- GAP_LEN, 8, fill symbols after the payload (0 = no gap state).
- FILL_SYM, 2'b00, symbol driven during the gap.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  allows new frames to start; sampled only in IDLE.
- src0_valid  in  1  source 0 AXIS TVALID.
- src0_data  in  2  source 0 symbol {i,q}.
- src0_ready  out  1  source 0 TREADY.
- src1_valid  in  1  source 1 TVALID.
- src1_data  in  2  source 1 symbol {i,q}.
- src1_ready  out  1  source 1 TREADY.
- out_valid  out  1  AXIS TVALID to modulator.
- out_data  out  2  symbol {i,q} to modulator.
- out_ready  in  1  modulator TREADY.
- grant  out  2  one-hot current grant; 2'b00 in IDLE.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse on the final gap symbol transfer, or on the final payload transfer if GAP_LEN=0.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; grant=0; busy=0; frame_done=0.
  - out_valid=0, out_data=0, src0_ready=0, src1_ready=0.
  - Counter cleared; last_grant=src1, so src0 wins the first tie.
- A "transfer" is out_valid & out_ready on a rising clk edge.
- IDLE:
  - out_valid=0; both src readies are 0.
  - If enable and any src valid: latch the grant and go to PRE next cycle.
  - If both srcs are valid, grant the source not in last_grant.
- PRE:
  - out_valid=1; out_data = pattern symbol[cnt], taken combinationally from the registered cnt.
  - cnt increments on each transfer.
  - On the transfer with cnt=PRE_LEN-1: clear cnt and go to PAY.
  - Src readies stay 0.
- PAY, combinational pass-through of the granted source:
  - out_valid = granted valid; out_data = granted data; granted ready = out_ready.
  - The other source's ready stays 0.
  - The source may stall (valid low): out_valid drops, cnt holds, and no fill is inserted.
  - On the transfer with cnt=FRAME_LEN-1: update last_grant. Go to GAP, or to IDLE if GAP_LEN=0 (frame_done pulses in that case).
- GAP:
  - out_valid=1; out_data=FILL_SYM; cnt increments on each transfer.
  - On the transfer with cnt=GAP_LEN-1: pulse frame_done and go to IDLE.
- out_ready low holds state and cnt in every state; out_data stays stable while valid and not ready.
- Once busy, enable is ignored; deasserting enable mid-frame lets the frame complete.
- Back-to-back frames: IDLE lasts exactly one cycle between frames when sources stay valid.
- grant is stable from PRE through GAP; it changes only on entry to PRE.
- cnt width is clog2 of max(PRE_LEN, FRAME_LEN, GAP_LEN, 2). No wrap is possible because cnt is cleared on every state change.
- Latency: enable and valid in IDLE -> first preamble symbol with out_valid=1 on the next cycle.

Test Plan:
- Reset with src0 valid and enable=1; release rst -> one IDLE cycle, then 16 preamble symbols 0,3,0,3,0,3,0,3,0,0,3,3,0,0,3,3 (PRE_PATTERN=32'hF0F0_CCCC, k=0 first), then 64 src0 symbols, then 8 × 2'b00 with frame_done on the last one; grant=01 throughout.
- Both sources continuously valid, out_ready=1 -> grants alternate 01,10,01 over three frames; each frame is 88 transfers (16+64+8) with one IDLE cycle between frames.
- src1 valid drops for 5 cycles mid-payload -> out_valid low for those 5 cycles, cnt holds, src0_ready stays 0; frame still carries exactly 64 payload symbols.
- Random out_ready at 50% -> no symbol lost or duplicated; out_data stable while out_valid & ~out_ready; src readies never high outside PAY.
- Deassert enable during PAY -> current frame completes with frame_done; scheduler then stays in IDLE with busy=0 while sources are valid.
- Assert rst=0 mid-preamble, asynchronously between clock edges -> all outputs go to reset values immediately; after release, the next frame starts at preamble symbol 0 and src0 is granted on a tie.
